// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Loads A/B matrices one k-slice per beat, then drives skewed,
//               zero-padded operand streams into an NxN output-stationary
//               systolic array with matching enable and a one-cycle clear.
//               Completion is signalled with a result_valid/result_ack
//               handshake.
//               Optional macro SYSTOLIC_FEEDER_JOB_COUNT_EN adds a 16-bit
//               completed-job counter output (job_count).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_valid,
    output logic                               load_ready,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0]   load_a_col,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0]   load_b_row,
    output logic [DATA_WIDTH-1:0]              a_inputs [0:ARRAY_SIZE-1],
    output logic [DATA_WIDTH-1:0]              b_inputs [0:ARRAY_SIZE-1],
    output logic                               array_enable,
    output logic                               array_clear,
    output logic                               result_valid,
`ifdef SYSTOLIC_FEEDER_JOB_COUNT_EN
    output logic [15:0]                        job_count,
`endif
    input  logic                               result_ack
);

    localparam int             CW          = $clog2(3*ARRAY_SIZE) + 1;
    localparam logic [CW-1:0]  c_LAST_BEAT = CW'(ARRAY_SIZE - 1);
    localparam logic [CW-1:0]  c_LAST_STEP = CW'(3*ARRAY_SIZE - 2);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_beat_cnt;
    logic [CW-1:0]          r_step_cnt;
    logic [CW-1:0]          w_step_nxt;
    logic                   w_fire;

    logic [DATA_WIDTH-1:0]  r_a_buf [ARRAY_SIZE][ARRAY_SIZE];   // [i][k]
    logic [DATA_WIDTH-1:0]  r_b_buf [ARRAY_SIZE][ARRAY_SIZE];   // [k][j]
    logic [DATA_WIDTH-1:0]  w_a_nxt [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]  w_b_nxt [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]  r_a_out [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]  r_b_out [ARRAY_SIZE];

    logic                   r_load_ready;
    logic                   r_enable;
    logic                   r_clear;
    logic                   r_result_valid;

    assign w_fire = load_valid && r_load_ready;

    // Next-state and next-step selection
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = '0;
        case (r_state)
            S_LOAD: begin
                if (w_fire && (r_beat_cnt == c_LAST_BEAT)) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (r_step_cnt == c_LAST_STEP) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_step_nxt = r_step_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (result_ack) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // State, beat counter and step counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_beat_cnt <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step_nxt;
            if (r_state != S_LOAD) begin
                r_beat_cnt <= '0;
            end else if (w_fire) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // Operand buffer capture; contents are don't-care until fully reloaded
    always_ff @(posedge clk) begin
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            if (w_fire && (r_beat_cnt == CW'(k))) begin
                for (int i = 0; i < ARRAY_SIZE; i++) begin
                    r_a_buf[i][k] <= load_a_col[i*DATA_WIDTH +: DATA_WIDTH];
                    r_b_buf[k][i] <= load_b_row[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Skew selection for the step that will be current next cycle; an index
    // t-i outside 0..N-1 simply matches no k, yielding the zero padding.
    always_comb begin
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            w_a_nxt[i] = '0;
            w_b_nxt[i] = '0;
        end
        if (w_state_nxt == S_STREAM) begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                for (int k = 0; k < ARRAY_SIZE; k++) begin
                    if (w_step_nxt == CW'(i + k)) begin
                        w_a_nxt[i] = r_a_buf[i][k];
                        w_b_nxt[i] = r_b_buf[k][i];
                    end
                end
            end
        end
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_ready   <= 1'b0;
            r_enable       <= 1'b0;
            r_clear        <= 1'b0;
            r_result_valid <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                r_a_out[i] <= '0;
                r_b_out[i] <= '0;
            end
        end else begin
            r_load_ready   <= (w_state_nxt == S_LOAD);
            r_enable       <= (w_state_nxt == S_STREAM);
            r_clear        <= (w_state_nxt == S_CLEAR);
            r_result_valid <= (w_state_nxt == S_DONE);
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                r_a_out[i] <= w_a_nxt[i];
                r_b_out[i] <= w_b_nxt[i];
            end
        end
    end

    assign load_ready   = r_load_ready;
    assign array_enable = r_enable;
    assign array_clear  = r_clear;
    assign result_valid = r_result_valid;

    generate
        for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_out
            assign a_inputs[g] = r_a_out[g];
            assign b_inputs[g] = r_b_out[g];
        end
    endgenerate

`ifdef SYSTOLIC_FEEDER_JOB_COUNT_EN
    logic [15:0] r_job_count;

    // Count completed jobs at each result_ack handshake; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_job_count <= '0;
        end else if ((r_state == S_DONE) && result_ack) begin
            r_job_count <= r_job_count + 16'd1;
        end
    end

    assign job_count = r_job_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Self-checking bench for systolic_feeder (N=4, DW=8). Drives
//               the load interface, checks the skewed streams against a
//               hand-computed table, and feeds a behavioural output-
//               stationary array whose accumulators are compared with a
//               reference matrix product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int DW = 8;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_valid;
    logic            load_ready;
    logic [DW*N-1:0] load_a_col;
    logic [DW*N-1:0] load_b_row;
    logic [DW-1:0]   a_inputs [0:N-1];
    logic [DW-1:0]   b_inputs [0:N-1];
    logic            array_enable;
    logic            array_clear;
    logic            result_valid;
    logic            result_ack;
`ifdef SYSTOLIC_FEEDER_JOB_COUNT_EN
    logic [15:0]     job_count;
`endif

    systolic_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_a_col   (load_a_col),
        .load_b_row   (load_b_row),
        .a_inputs     (a_inputs),
        .b_inputs     (b_inputs),
        .array_enable (array_enable),
        .array_clear  (array_clear),
        .result_valid (result_valid),
`ifdef SYSTOLIC_FEEDER_JOB_COUNT_EN
        .job_count    (job_count),
`endif
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;

    logic [31:0] a_pk;
    logic [31:0] b_pk;
    assign a_pk = {a_inputs[3], a_inputs[2], a_inputs[1], a_inputs[0]};
    assign b_pk = {b_inputs[3], b_inputs[2], b_inputs[1], b_inputs[0]};

    // Count accepted load beats
    always @(posedge clk) begin
        if (load_valid && load_ready) hs_cnt <= hs_cnt + 1;
    end

    // Behavioural output-stationary array fed by the DUT streams
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    int            acc [N][N];
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || array_clear) begin
                    acc[i][j] <= 0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else if (array_enable) begin
                    acc[i][j] <= acc[i][j] +
                        ((j == 0) ? a_inputs[i] : pa[i][(j == 0) ? 0 : j-1]) *
                        ((i == 0) ? b_inputs[j] : pb[(i == 0) ? 0 : i-1][j]);
                    pa[i][j]  <= (j == 0) ? a_inputs[i] : pa[i][(j == 0) ? 0 : j-1];
                    pb[i][j]  <= (i == 0) ? b_inputs[j] : pb[(i == 0) ? 0 : i-1][j];
                end
            end
        end
    end

    typedef struct {
        int          t;
        logic [31:0] a;   // {a3,a2,a1,a0}
        logic [31:0] b;   // {b3,b2,b1,b0}
    } vec_t;
    vec_t tbl [11];

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int s);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                case (s)
                    1: begin ma[i][k] = DW'(i*4 + k + 1);     mb[i][k] = DW'(i*4 + k + 1); end
                    2: begin ma[i][k] = DW'(i + 2*k + 1);     mb[i][k] = DW'((3*i + k) % 5 + 1); end
                    default: begin ma[i][k] = DW'(255 - i*16 - k); mb[i][k] = DW'(200 + i + k); end
                endcase
            end
        end
    endtask

    // Present N beats; optional idle gap between beats, optional valid held after
    task automatic load_job(input bit gaps, input bit hold);
        bit accepted;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                load_a_col[i*DW +: DW] = ma[i][k];
                load_b_row[i*DW +: DW] = mb[k][i];
            end
            load_valid = 1'b1;
            accepted   = 1'b0;
            for (int w = 0; w < 20 && !accepted; w++) begin
                accepted = load_ready;
                tick();
            end
            chk("beat_accept", 64'(accepted), 64'd1);
            if (gaps && k != N-1) begin
                load_valid = 1'b0;
                tick();
            end
        end
        if (!hold) load_valid = 1'b0;
    endtask

    task automatic clear_checks();
        chk("clear_pulse", 64'(array_clear), 64'd1);
        chk("clear_enable", 64'(array_enable), 64'd0);
        chk("clear_ready", 64'(load_ready), 64'd0);
        chk("clear_streams", {a_pk, b_pk}, 64'd0);
    endtask

    task automatic run_stream(input bit use_tbl);
        for (int r = 0; r < 11; r++) begin
            if (use_tbl) begin
                chk($sformatf("stream_a_t%0d", tbl[r].t), 64'(a_pk), 64'(tbl[r].a));
                chk($sformatf("stream_b_t%0d", tbl[r].t), 64'(b_pk), 64'(tbl[r].b));
            end
            chk("stream_enable", 64'(array_enable), 64'd1);
            chk("stream_valid", 64'(result_valid), 64'd0);
            tick();
        end
    endtask

    task automatic done_checks();
        int ref_c;
        chk("done_valid", 64'(result_valid), 64'd1);
        chk("done_enable", 64'(array_enable), 64'd0);
        chk("done_streams", {a_pk, b_pk}, 64'd0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ref_c = 0;
                for (int k = 0; k < N; k++) ref_c += int'(ma[i][k]) * int'(mb[k][j]);
                chk($sformatf("C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(ref_c));
            end
        end
    endtask

    task automatic ack_job();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ack_valid_low", 64'(result_valid), 64'd0);
        chk("ack_ready_high", 64'(load_ready), 64'd1);
    endtask

    initial begin
        int hs0;
        tbl[0]  = '{0,  32'h00000001, 32'h00000001};
        tbl[1]  = '{1,  32'h00000502, 32'h00000205};
        tbl[2]  = '{2,  32'h00090603, 32'h00030609};
        tbl[3]  = '{3,  32'h0D0A0704, 32'h04070A0D};
        tbl[4]  = '{4,  32'h0E0B0800, 32'h080B0E00};
        tbl[5]  = '{5,  32'h0F0C0000, 32'h0C0F0000};
        tbl[6]  = '{6,  32'h10000000, 32'h10000000};
        tbl[7]  = '{7,  32'h00000000, 32'h00000000};
        tbl[8]  = '{8,  32'h00000000, 32'h00000000};
        tbl[9]  = '{9,  32'h00000000, 32'h00000000};
        tbl[10] = '{10, 32'h00000000, 32'h00000000};

        rst = 1'b1; load_valid = 1'b0; result_ack = 1'b0;
        load_a_col = '0; load_b_row = '0;
        tick(); tick();
        chk("rst_ready", 64'(load_ready), 64'd0);
        chk("rst_streams", {a_pk, b_pk}, 64'd0);
        chk("rst_enable", 64'(array_enable), 64'd0);
        chk("rst_clear", 64'(array_clear), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(load_ready), 64'd1);

        // Job aborted by reset in the middle of the stream
        set_data(1);
        load_job(1'b0, 1'b0);
        clear_checks();
        tick();
        for (int t = 0; t < 5; t++) tick();
        chk("abort_t5_a", 64'(a_pk), 64'(tbl[5].a));
        rst = 1'b1;
        #2;
        chk("abort_ready", 64'(load_ready), 64'd0);
        chk("abort_streams", {a_pk, b_pk}, 64'd0);
        chk("abort_enable", 64'(array_enable), 64'd0);
        chk("abort_valid", 64'(result_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_reload_ready", 64'(load_ready), 64'd1);

        // Job 1: main directed data, table-checked streams
        set_data(1);
        hs0 = hs_cnt;
        load_job(1'b0, 1'b0);
        clear_checks();
        tick();
        run_stream(1'b1);
        done_checks();
        chk("C00_const", 64'(acc[0][0]), 64'd90);
        chk("C33_const", 64'(acc[3][3]), 64'd600);
        chk("job1_beats", 64'(hs_cnt - hs0), 64'd4);
        ack_job();

        // Job 2: gapped beats, valid held high after the load, long DONE wait
        set_data(2);
        hs0 = hs_cnt;
        load_job(1'b1, 1'b1);
        clear_checks();
        tick();
        run_stream(1'b0);
        done_checks();
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("wait_valid", 64'(result_valid), 64'd1);
            chk("wait_enable", 64'(array_enable), 64'd0);
        end
        chk("job2_beats", 64'(hs_cnt - hs0), 64'd4);
        load_valid = 1'b0;
        ack_job();

        // Job 3: full-range element values
        set_data(3);
        hs0 = hs_cnt;
        load_job(1'b0, 1'b0);
        clear_checks();
        tick();
        run_stream(1'b0);
        done_checks();
        chk("job3_beats", 64'(hs_cnt - hs0), 64'd4);
        ack_job();
`ifdef SYSTOLIC_FEEDER_JOB_COUNT_EN
        chk("job_count", 64'(job_count), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
